// File: rtl/sc_fifo_ram_if.sv
// Handshake bundle for sc_fifo_ram: write/read requests, synchronous clear and status outputs.
// The master modport is the user side; the slave modport is the FIFO itself.
interface sc_fifo_ram_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 11
) ();

  logic                  sclr;
  logic [DATA_WIDTH-1:0] data;
  logic                  wrreq;
  logic                  rdreq;
  logic [DATA_WIDTH-1:0] q;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH-1:0] usedw;

  modport master (
    output sclr,
    output data,
    output wrreq,
    output rdreq,
    input  q,
    input  empty,
    input  full,
    input  usedw
  );

  modport slave (
    input  sclr,
    input  data,
    input  wrreq,
    input  rdreq,
    output q,
    output empty,
    output full,
    output usedw
  );

endinterface

// File: rtl/sc_fifo_ram.sv
// Single-clock line-buffer FIFO on an inferred simple dual-port RAM, legacy (registered) read.
// Define FIFO_ASSERT_EN to compile simulation checks that stop on overflow/underflow requests.
module sc_fifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter string       RAM_STYLE  = "M10K"
) (
  input logic            clk,
  input logic            aclr,
  sc_fifo_ram_if.slave   fifo
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;

  localparam cnt_t CntFull = cnt_t'(DEPTH);

  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  cnt_t                  count_q, count_d;
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  empty;
  logic                  full;
  logic                  wr_en;
  logic                  rd_en;

  // Flags are pure decodes of the registered count, so no request reaches an output.
  assign empty = (count_q == '0);
  assign full  = (count_q == CntFull);

  always_comb begin
    wr_en    = fifo.wrreq && !full && !fifo.sclr;
    rd_en    = fifo.rdreq && !empty && !fifo.sclr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    q_d      = q_q;
    if (fifo.sclr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      q_d      = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
        q_d      = rd_word;
      end
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      q_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      q_q      <= q_d;
    end
  end

  // Storage array carries no reset so it can map onto block RAM; q_q is its output register.
  if (RAM_STYLE == "logic") begin : g_reg_ram
    (* ramstyle = "logic" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_ptr_q] <= fifo.data;
      end
    end

    assign rd_word = mem[rd_ptr_q];
  end else begin : g_block_ram
    (* ramstyle = "M10K" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_ptr_q] <= fifo.data;
      end
    end

    assign rd_word = mem[rd_ptr_q];
  end

  assign fifo.q     = q_q;
  assign fifo.empty = empty;
  assign fifo.full  = full;
  assign fifo.usedw = count_q[ADDR_WIDTH-1:0];

`ifdef FIFO_ASSERT_EN
  always @(posedge clk) begin
    if (!aclr && fifo.wrreq && full) begin
      $fatal(1, "FIFO FULL");
    end
    if (!aclr && fifo.rdreq && empty) begin
      $fatal(1, "FIFO EMPTY");
    end
  end
`else
`endif

endmodule

// File: tb/tb_sc_fifo_ram.sv
// Directed bench for sc_fifo_ram at DEPTH=16: reset, fill/drain, over/underflow,
// simultaneous access, pointer wrap streaming, sclr and aclr behaviour.
module tb_sc_fifo_ram;

  logic clk;
  logic aclr;
  int   n_cmp;
  int   n_bad;

  sc_fifo_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  sc_fifo_ram #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .RAM_STYLE ("M10K")
  ) dut (
    .clk (clk),
    .aclr(aclr),
    .fifo(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] q, input logic e,
                             input logic f, input logic [3:0] u);
    check({tag, ".q"},     32'(bus.q),     32'(q));
    check({tag, ".empty"}, 32'(bus.empty), 32'(e));
    check({tag, ".full"},  32'(bus.full),  32'(f));
    check({tag, ".usedw"}, 32'(bus.usedw), 32'(u));
  endtask

  initial begin
    int       cnt;
    int       written;
    int       cyc;
    bit       up;
    bit       wr;
    bit       rd;
    logic [7:0] wv;
    logic [7:0] rv;

    n_cmp     = 0;
    n_bad     = 0;
    aclr      = 1'b0;
    bus.sclr  = 1'b0;
    bus.data  = '0;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;

    // Reset: asynchronous, observed without a clock edge after release.
    #2 aclr = 1'b1;
    #1 check_state("aclr_held", 8'h00, 1'b1, 1'b0, 4'd0);
    #1 aclr = 1'b0;
    #1 check_state("aclr_rel", 8'h00, 1'b1, 1'b0, 4'd0);
    repeat (5) step();
    check_state("idle5", 8'h00, 1'b1, 1'b0, 4'd0);

    // Fill 0x01..0x10.
    for (int i = 1; i <= 16; i++) begin
      bus.data  = 8'(i);
      bus.wrreq = 1'b1;
      step();
      if (i == 1) check_state("first_wr", 8'h00, 1'b0, 1'b0, 4'd1);
    end
    bus.wrreq = 1'b0;
    check_state("filled", 8'h00, 1'b0, 1'b1, 4'd0);

    // Overflow attempt is dropped.
    bus.data  = 8'hAA;
    bus.wrreq = 1'b1;
    step();
    bus.wrreq = 1'b0;
    check_state("overflow", 8'h00, 1'b0, 1'b1, 4'd0);

    // Drain in order.
    for (int i = 1; i <= 16; i++) begin
      bus.rdreq = 1'b1;
      step();
      check("drain.q", 32'(bus.q), 32'(i));
      check("drain.usedw", 32'(bus.usedw), 32'((16 - i) & 15));
    end
    check_state("drained", 8'h10, 1'b1, 1'b0, 4'd0);

    // Underflow: q holds.
    step();
    bus.rdreq = 1'b0;
    check_state("underflow", 8'h10, 1'b1, 1'b0, 4'd0);

    // wr+rd while empty: only the write lands.
    bus.data  = 8'h55;
    bus.wrreq = 1'b1;
    bus.rdreq = 1'b1;
    step();
    bus.wrreq = 1'b0;
    check_state("wr_rd_empty", 8'h10, 1'b0, 1'b0, 4'd1);
    step();
    bus.rdreq = 1'b0;
    check_state("wr_rd_empty_out", 8'h55, 1'b1, 1'b0, 4'd0);

    // Hold occupancy at 5 with concurrent wr+rd for 100 cycles.
    wv = 8'h20;
    rv = 8'h20;
    bus.wrreq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.data = wv;
      wv++;
      step();
    end
    check("at5.usedw", 32'(bus.usedw), 32'd5);
    bus.rdreq = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.data = wv;
      wv++;
      step();
      check("simul.q", 32'(bus.q), 32'(rv));
      check("simul.usedw", 32'(bus.usedw), 32'd5);
      rv++;
    end
    bus.wrreq = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("simul_drain.q", 32'(bus.q), 32'(rv));
      rv++;
    end
    bus.rdreq = 1'b0;
    check("simul_done.empty", 32'(bus.empty), 32'd1);

    // Stream 1000 bytes across many pointer wraps, occupancy kept within 3..14.
    wv      = 8'h00;
    rv      = 8'h00;
    cnt     = 0;
    written = 0;
    cyc     = 0;
    up      = 1'b1;
    while (written < 1000 || cnt > 0) begin
      if (up && cnt >= 14) up = 1'b0;
      if (!up && cnt <= 3) up = 1'b1;
      if (written >= 1000) begin
        wr = 1'b0;
        rd = 1'b1;
      end else if (cnt < 3) begin
        wr = 1'b1;
        rd = 1'b0;
      end else if (up) begin
        wr = 1'b1;
        rd = (cyc % 3 == 0);
      end else begin
        wr = (cyc % 3 == 0);
        rd = 1'b1;
      end
      bus.wrreq = wr;
      bus.rdreq = rd;
      bus.data  = wv;
      step();
      if (wr) begin
        wv++;
        written++;
        cnt++;
      end
      if (rd) begin
        check("stream.q", 32'(bus.q), 32'(rv));
        rv++;
        cnt--;
      end
      cyc++;
    end
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    check_state("stream_end", 8'hE7, 1'b1, 1'b0, 4'd0);

    // sclr with 7 stored and a concurrent write.
    bus.wrreq = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.data = 8'(8'h60 + i);
      step();
    end
    check("pre_sclr.usedw", 32'(bus.usedw), 32'd7);
    bus.sclr = 1'b1;
    bus.data = 8'h77;
    step();
    bus.sclr  = 1'b0;
    bus.wrreq = 1'b0;
    check_state("sclr", 8'h00, 1'b1, 1'b0, 4'd0);
    step();
    check_state("sclr_idle", 8'h00, 1'b1, 1'b0, 4'd0);
    bus.data  = 8'h88;
    bus.wrreq = 1'b1;
    step();
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b1;
    step();
    bus.rdreq = 1'b0;
    check_state("post_sclr", 8'h88, 1'b1, 1'b0, 4'd0);

    // aclr mid-cycle while writing.
    bus.wrreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data = 8'(8'h90 + i);
      step();
    end
    bus.rdreq = 1'b1;
    step();
    check("pre_aclr.q", 32'(bus.q), 32'h90);
    #2 aclr = 1'b1;
    #1 check_state("aclr_mid", 8'h00, 1'b1, 1'b0, 4'd0);
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    #1 aclr = 1'b0;
    step();
    check_state("aclr_after", 8'h00, 1'b1, 1'b0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
